codec_i2c_target: RTL and testbench
===================================

CODEC_I2C_TARGET -- requirements
Module: codec_i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, 7-bit I2C device address to respond to (write byte 8'h34).
REQ-002 Parameter NREGS, default 16, number of stored 9-bit codec registers.
REQ-003 clk  input  1  system clock (50 MHz).
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 I2C_SCLK  input  1  I2C clock from the bus initiator.
REQ-006 I2C_SDAT  inout  1  I2C data, driven only to 0 (ACK), else high-Z.
REQ-007 wr_valid  output  1  one-clk pulse when a register write commits.
REQ-008 wr_addr  output  7  register address of the committed write.
REQ-009 wr_data  output  9  data of the committed write.
REQ-010 rd_addr  input  4  register-file read index.
REQ-011 rd_data  output  9  combinational register-file content at rd_addr.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 soft_reset  output  1  one-clk pulse on a write to register 7'h0F.

Function
REQ-014 SCL and SDA inputs shall pass a 2-flop synchronizer plus one history flop; all bus events derive from the synchronized values.
REQ-015 START = synchronized SDA 1->0 while SCL high; STOP = SDA 0->1 while SCL high; both are recognized in every state.
REQ-016 START in any state shall enter ADDR with bit counter 0; STOP in any state shall enter IDLE and release SDA.
REQ-017 Data bits shall be sampled MSB-first on synchronized SCL rising edges; a 3-bit counter counts 0..7 per byte, wrapping after 8 bits.
REQ-018 FSM states: IDLE, ADDR, ACK_ADDR, REG_BYTE, ACK_REG, DATA_BYTE, ACK_DATA, IGNORE.
REQ-019 ADDR: after 8 bits, byte == {DEV_ADDR,1'b0} -> ACK_ADDR; otherwise (address mismatch or R/W=1) -> IGNORE with no ACK.
REQ-020 ACK states: SDA driven low from the SCL falling edge after bit 8 until the next SCL falling edge, then advance.
REQ-021 REG_BYTE: bits[7:1] latched as register address, bit 0 as data[8]; always ACKed.
REQ-022 DATA_BYTE: bits latched as data[7:0]; always ACKed; the write commits one clk after the 8th SCL rising edge.
REQ-023 Commit: wr_valid=1 for exactly one clk with wr_addr/wr_data; regfile[wr_addr] updated when wr_addr < NREGS, else wr_valid still pulses and nothing is stored.
REQ-024 Commit with wr_addr == 7'h0F shall clear every regfile entry to 9'h000 and pulse soft_reset in the same clk.
REQ-025 After ACK_DATA the FSM enters IGNORE; further bytes are not ACKed and not stored until START or STOP.
REQ-026 STOP or START before DATA_BYTE completes shall discard the partial transfer with no wr_valid.
REQ-027 rd_data reflects the register array combinationally; on a same-clk commit to rd_addr it shows the old value, and the new value from the next clk.
REQ-028 IGNORE never drives SDA.

Reset
REQ-029 On nrst low: FSM=IDLE, SDA released, wr_valid=0, soft_reset=0, wr_addr=0, wr_data=0, busy=0, all regfile entries 9'h000, synchronizer flops=1 (idle bus).
REQ-030 Reset mid-transfer shall abort immediately; after release the block waits for a new START.

Structure
REQ-031 A shared package shall hold the FSM state enum, the DEV_ADDR default, and codec register index constants (PW_DOWN_CTRL=6, AUDIO_FORMAT=7, SAMPLE_CTRL=8, ACTIVE=9, RESET=15).
REQ-032 The synchronizer and edge/START/STOP detector shall be one sub-module, i2c_bus_monitor.

Verification
REQ-033 Write 34,0C,00 at 100 kHz SCL -> 3 ACKs, wr_valid once with wr_addr=7'h06, wr_data=9'h000; rd_addr=6 gives 9'h000.
REQ-034 Write 34,04,7F -> wr_addr=7'h02, wr_data=9'h07F; rd_addr=2 gives 9'h07F.
REQ-035 Write 36,0C,00 -> no ACK on any byte, no wr_valid, regfile unchanged, busy=1 until STOP.
REQ-036 Write 34,12 then STOP -> 2 ACKs, no wr_valid; then a full write 34,12,01 -> wr_addr=7'h09, wr_data=9'h001.
REQ-037 After loading regs 2 and 9, write 34,1E,00 -> soft_reset pulse, rd_data=9'h000 for all indices.
REQ-038 nrst asserted during DATA_BYTE bit 4 -> SDA released, no wr_valid; the next full transaction commits normally.

Source files
------------

// File: rtl/codec_i2c_target_pkg.sv
// codec_i2c_target_pkg: shared FSM states, device address default and codec register indices
package codec_i2c_target_pkg;
   localparam logic [6:0] DEV_ADDR_DEF = 7'h1A;
   localparam logic [6:0] PW_DOWN_CTRL = 7'd6;
   localparam logic [6:0] AUDIO_FORMAT = 7'd7;
   localparam logic [6:0] SAMPLE_CTRL  = 7'd8;
   localparam logic [6:0] ACTIVE       = 7'd9;
   localparam logic [6:0] RESET        = 7'd15;
   typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, REG_BYTE, ACK_REG, DATA_BYTE, ACK_DATA, IGNORE} state_t;
endpackage

// File: rtl/codec_i2c_target_i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions
module i2c_bus_monitor (
   input  logic clk,
   input  logic nrst,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic sda_s
);
   logic [2:0] scl_ff, sda_ff;
   // two synchronizer stages plus one history stage, reset to the idle-high bus level
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         scl_ff <= '1;
         sda_ff <= '1;
      end else begin
         scl_ff <= {scl_ff[1:0], scl};
         sda_ff <= {sda_ff[1:0], sda};
      end
   assign sda_s    = sda_ff[1];
   assign scl_rise = scl_ff[1] & ~scl_ff[2];
   assign scl_fall = ~scl_ff[1] & scl_ff[2];
   assign start    = scl_ff[1] & scl_ff[2] & sda_ff[2] & ~sda_ff[1];
   assign stop     = scl_ff[1] & scl_ff[2] & ~sda_ff[2] & sda_ff[1];
endmodule

// File: rtl/codec_i2c_target.sv
// codec_i2c_target: write-only I2C target storing 9-bit codec registers from 3-byte transfers
module codec_i2c_target
   import codec_i2c_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
   parameter int         NREGS    = 16
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       I2C_SCLK,
   inout  wire        I2C_SDAT,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   input  logic [3:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       busy,
   output logic       soft_reset
);
   localparam int AW = $clog2(NREGS);
   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg, nxt;
   logic [6:0] reg_addr;
   logic       d8, sda_oe, sda_s, scl_rise, scl_fall, start, stop;
   logic [8:0] regs [NREGS];

   i2c_bus_monitor u_mon (
      .clk(clk), .nrst(nrst), .scl(I2C_SCLK), .sda(I2C_SDAT),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop), .sda_s(sda_s)
   );

   assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
   assign nxt      = {shreg[6:0], sda_s};
   assign busy     = state != IDLE;
   assign rd_data  = (32'(rd_addr) < NREGS) ? regs[rd_addr[AW-1:0]] : '0;

   // protocol FSM: byte shifting, ACK windows on SCL falls, commit pulse after the data byte
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         reg_addr   <= '0;
         d8         <= 1'b0;
         sda_oe     <= 1'b0;
         wr_valid   <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         soft_reset <= 1'b0;
      end else begin
         wr_valid   <= 1'b0;
         soft_reset <= 1'b0;
         if (stop) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
         end else if (start) begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
         end else case (state)
            ADDR, REG_BYTE, DATA_BYTE: if (scl_rise) begin
               shreg   <= nxt;
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (state == ADDR) state <= (nxt == {DEV_ADDR, 1'b0}) ? ACK_ADDR : IGNORE;
                  else if (state == REG_BYTE) begin
                     reg_addr <= nxt[7:1];
                     d8       <= nxt[0];
                     state    <= ACK_REG;
                  end else begin
                     wr_valid   <= 1'b1;
                     wr_addr    <= reg_addr;
                     wr_data    <= {d8, nxt};
                     soft_reset <= reg_addr == RESET;
                     state      <= ACK_DATA;
                  end
               end
            end
            ACK_ADDR, ACK_REG, ACK_DATA: if (scl_fall) begin
               sda_oe <= ~sda_oe;
               if (sda_oe) state <= (state == ACK_ADDR) ? REG_BYTE : (state == ACK_REG) ? DATA_BYTE : IGNORE;
            end
            default: ;
         endcase
      end

   // register file: soft reset clears everything, otherwise in-range commits are stored
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      else if (soft_reset) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      else if (wr_valid && 32'(wr_addr) < NREGS) regs[wr_addr[AW-1:0]] <= wr_data;
endmodule

// File: tb/tb_codec_i2c_target.sv
// tb_codec_i2c_target: directed I2C writes checked against a transaction-level register model
`timescale 1ns/1ps
module tb_codec_i2c_target;
   logic       clk = 1'b0, nrst = 1'b0, scl = 1'b1, sda_low = 1'b0, sweep = 1'b1;
   logic [3:0] rd_addr = '0;
   wire        sda;
   logic       wr_valid, busy, soft_reset;
   logic [6:0] wr_addr;
   logic [8:0] wr_data, rd_data;
   logic [3:0] acks;
   logic       a;
   int         checks = 0, errors = 0, commits = 0, soft_pulses = 0, q = 2500;
   typedef struct {logic [6:0] a; logic [8:0] d;} exp_t;
   exp_t       exp_q[$];
   logic [8:0] model [16];

   pullup (sda);
   assign sda = sda_low ? 1'b0 : 1'bz;
   always #10 clk = ~clk;

   codec_i2c_target dut (
      .clk(clk), .nrst(nrst), .I2C_SCLK(scl), .I2C_SDAT(sda),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .soft_reset(soft_reset)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // every cycle: reset values, register contents and commit pulses against the model
   always @(negedge clk) begin
      exp_t e;
      if (!nrst) begin
         foreach (model[i]) model[i] = '0;
         exp_q.delete();
         chk("rst_wr_valid", wr_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_soft_reset", soft_reset, 0);
         chk("rst_wr_addr", wr_addr, 0);
         chk("rst_wr_data", wr_data, 0);
         chk("rst_rd_data", rd_data, 0);
         chk("rst_sda", sda, 1);
      end else begin
         chk("rd_data", rd_data, model[rd_addr]);
         if (soft_reset) soft_pulses++;
         if (wr_valid) begin
            commits++;
            chk("commit_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", wr_addr, e.a);
               chk("wr_data", wr_data, e.d);
               chk("soft_reset", soft_reset, e.a == 7'h0F);
               if (e.a == 7'h0F) foreach (model[i]) model[i] = '0;
               else if (e.a < 16) model[e.a[3:0]] = e.d;
            end
         end else chk("soft_reset_idle", soft_reset, 0);
      end
   end

   initial forever begin
      @(posedge clk);
      #2;
      if (sweep) rd_addr = rd_addr + 4'd1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic bus_start();
      sda_low = 1'b0; scl = 1'b1; #q;
      sda_low = 1'b1; #q;
      scl = 1'b0; #q;
   endtask

   task automatic bus_stop();
      sda_low = 1'b1; #q;
      scl = 1'b1; #q;
      sda_low = 1'b0; #(2*q);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_low = !b[i]; #q;
         scl = 1'b1; #(2*q);
         scl = 1'b0; #q;
      end
   endtask

   task automatic get_ack(output logic ack);
      sda_low = 1'b0; #q;
      scl = 1'b1; #q;
      ack = (sda === 1'b0); #q;
      scl = 1'b0; #q;
   endtask

   task automatic txn(input logic [31:0] bytes, input int n, input bit do_stop, output logic [3:0] ak);
      logic [7:0] b;
      logic       k;
      ak = '0;
      if (bytes[31:24] == 8'h34 && n >= 3) exp_q.push_back('{bytes[23:17], {bytes[16], bytes[15:8]}});
      bus_start();
      for (int i = 0; i < n; i++) begin
         b = bytes[31-8*i -: 8];
         send_bits(b, 8);
         get_ack(k);
         ak[i] = k;
         chk("ack_model", k, bytes[31:24] == 8'h34 && i < 3);
      end
      if (do_stop) begin
         bus_stop();
         #200;
         chk("commit_done", exp_q.size(), 0);
      end
   endtask

   task automatic peek(input string name, input logic [3:0] idx, input logic [8:0] exp);
      sweep = 1'b0;
      rd_addr = idx;
      #100;
      chk(name, rd_data, exp);
      sweep = 1'b1;
   endtask

   initial begin
      #105 nrst = 1'b1;
      #200;
      txn(32'h340C0000, 3, 1, acks);
      chk("t1_acks", acks, 4'b0111);
      peek("t1_rd6", 4'd6, 9'h000);
      q = 500;
      txn(32'h34047F00, 3, 1, acks);
      chk("t2_acks", acks, 4'b0111);
      peek("t2_rd2", 4'd2, 9'h07F);
      txn(32'h360C0000, 3, 0, acks);
      chk("t3_acks", acks, 4'b0000);
      chk("t3_busy", busy, 1);
      bus_stop();
      #200;
      chk("t3_idle", busy, 0);
      chk("t3_commits", commits, 2);
      txn(32'h34120000, 2, 1, acks);
      chk("t4_acks", acks, 4'b0011);
      chk("t4_commits", commits, 2);
      txn(32'h34120100, 3, 1, acks);
      chk("t5_acks", acks, 4'b0111);
      peek("t5_rd9", 4'd9, 9'h001);
      txn(32'h340455AA, 4, 1, acks);
      chk("t6_acks", acks, 4'b0111);
      peek("t6_rd2", 4'd2, 9'h055);
      txn(32'h34412300, 3, 1, acks);
      chk("t7_commits", commits, 5);
      peek("t7_rd0", 4'd0, 9'h000);
      txn(32'h341E0000, 3, 1, acks);
      chk("t8_soft_pulses", soft_pulses, 1);
      for (int i = 0; i < 16; i++) peek("t8_cleared", 4'(i), 9'h000);
      txn(32'h34047F00, 3, 1, acks);
      peek("t9_rd2", 4'd2, 9'h07F);
      bus_start();
      send_bits(8'h34, 8); get_ack(a);
      chk("t10_ack0", a, 1);
      send_bits(8'h04, 8); get_ack(a);
      chk("t10_ack1", a, 1);
      send_bits(8'h7F, 3);
      sda_low = 1'b0; #q;
      scl = 1'b1; #q;
      nrst = 1'b0;
      #50;
      chk("t10_sda_released", sda, 1);
      chk("t10_no_commit", wr_valid, 0);
      #q scl = 1'b0;
      #q scl = 1'b1;
      #200 nrst = 1'b1;
      #200;
      chk("t10_busy", busy, 0);
      peek("t10_rd2_reset", 4'd2, 9'h000);
      chk("t10_commits", commits, 7);
      txn(32'h3410AB00, 3, 1, acks);
      chk("t11_acks", acks, 4'b0111);
      peek("t11_rd8", 4'd8, 9'h0AB);
      chk("t11_commits", commits, 8);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
